drr_flow_scheduler: RTL

- Deficit-round-robin scheduler that shares the packet-generator command FIFO write slot between N_FLOWS packet managers.
- Drop-in replacement for the plain flow arbiter: same request/acknowledge/grant handshake, with byte fairness by per-flow quantum.
- Per-flow quantum and enable are written at runtime through the existing cfg_en/cfg_id configuration strobe from the AXI-lite config interface.

---
 rtl/drr_flow_scheduler.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/drr_flow_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : drr_flow_scheduler
//  Purpose  : Deficit-round-robin arbiter sharing the packet-generator command
//             FIFO write slot between N_FLOWS flow managers, with byte fairness
//             set by a runtime-programmable per-flow quantum and enable.
//  Revision : 1.0 - initial release
// ============================================================================
module drr_flow_scheduler #(
  parameter int N_FLOWS       = 4,
  parameter int SIZE_WIDTH    = 11,
  parameter int QUANTUM_WIDTH = 16,
  parameter int DEFICIT_WIDTH = 17,
  parameter logic [N_FLOWS*QUANTUM_WIDTH-1:0] QUANTUMS = {4{16'd1536}},
  localparam int ID_WIDTH     = (N_FLOWS > 1) ? $clog2(N_FLOWS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_FLOWS-1:0]               request,
  input  logic [N_FLOWS*SIZE_WIDTH-1:0]    req_size,
  input  logic [N_FLOWS-1:0]               acknowledge,
  output logic [N_FLOWS-1:0]               grant,
  output logic                             grant_valid,
  output logic [ID_WIDTH-1:0]              grant_id,
  input  logic                             cfg_en,
  input  logic [ID_WIDTH-1:0]              cfg_id,
  input  logic [QUANTUM_WIDTH-1:0]         cfg_quantum,
  input  logic                             cfg_flow_en
);

  typedef enum logic [0:0] {SCAN = 1'b0, GRANT = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [ID_WIDTH-1:0]        ptr_q, ptr_d;
  logic                       refilled_q, refilled_d;
  logic [DEFICIT_WIDTH-1:0]   deficit_q [N_FLOWS];
  logic [DEFICIT_WIDTH-1:0]   deficit_d [N_FLOWS];
  logic [QUANTUM_WIDTH-1:0]   quantum_q [N_FLOWS];
  logic [QUANTUM_WIDTH-1:0]   quantum_d [N_FLOWS];
  logic [N_FLOWS-1:0]         flow_en_q, flow_en_d;
  logic [N_FLOWS-1:0]         grant_q, grant_d;
  logic [SIZE_WIDTH-1:0]      size_q, size_d;

  logic [SIZE_WIDTH-1:0]      w_size_arr  [N_FLOWS];
  logic [QUANTUM_WIDTH-1:0]   w_quant_rst [N_FLOWS];
  logic [ID_WIDTH-1:0]        w_ptr_next;
  logic                       w_eligible;
  logic [DEFICIT_WIDTH-1:0]   w_cur_deficit;
  logic [SIZE_WIDTH-1:0]      w_cur_size;
  logic [DEFICIT_WIDTH:0]     w_refill_sum;
  logic [DEFICIT_WIDTH-1:0]   w_refill_sat;

  // Unpack the flat per-flow size bus and reset quanta into arrays
  generate
    for (genvar i = 0; i < N_FLOWS; i++) begin : g_unpack
      assign w_size_arr[i]  = req_size[i*SIZE_WIDTH +: SIZE_WIDTH];
      assign w_quant_rst[i] = QUANTUMS[i*QUANTUM_WIDTH +: QUANTUM_WIDTH];
    end
  endgenerate

  assign w_ptr_next    = (ptr_q == ID_WIDTH'(N_FLOWS - 1)) ? '0 : ptr_q + 1'b1;
  assign w_eligible    = request[ptr_q] & flow_en_q[ptr_q];
  assign w_cur_deficit = deficit_q[ptr_q];
  assign w_cur_size    = w_size_arr[ptr_q];
  // One extra bit catches the carry so the refill can saturate instead of wrapping
  assign w_refill_sum  = {1'b0, w_cur_deficit} + (DEFICIT_WIDTH+1)'(quantum_q[ptr_q]);
  assign w_refill_sat  = w_refill_sum[DEFICIT_WIDTH] ? '1 : w_refill_sum[DEFICIT_WIDTH-1:0];

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = ptr_q;

  // Next-state: configuration writes plus the SCAN/GRANT scheduling decision
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    refilled_d = refilled_q;
    flow_en_d  = flow_en_q;
    grant_d    = grant_q;
    size_d     = size_q;
    for (int i = 0; i < N_FLOWS; i++) begin
      deficit_d[i] = deficit_q[i];
      quantum_d[i] = quantum_q[i];
    end

    if (cfg_en && (int'(cfg_id) < N_FLOWS)) begin
      quantum_d[cfg_id] = cfg_quantum;
      flow_en_d[cfg_id] = cfg_flow_en;
    end

    case (state_q)
      SCAN: begin
        if (!w_eligible) begin
          // Idle or disabled flows forfeit any banked credit
          deficit_d[ptr_q] = '0;
          ptr_d            = w_ptr_next;
          refilled_d       = 1'b0;
        end else if (w_cur_deficit >= DEFICIT_WIDTH'(w_cur_size)) begin
          size_d         = w_cur_size;
          grant_d        = '0;
          grant_d[ptr_q] = 1'b1;
          state_d        = GRANT;
        end else if (!refilled_q) begin
          deficit_d[ptr_q] = w_refill_sat;
          refilled_d       = 1'b1;
        end else begin
          // Already topped up this visit: keep the credit and move on
          ptr_d      = w_ptr_next;
          refilled_d = 1'b0;
        end
      end
      GRANT: begin
        if (acknowledge[ptr_q]) begin
          // Deficit was >= size at grant time, so this cannot underflow
          deficit_d[ptr_q] = w_cur_deficit - DEFICIT_WIDTH'(size_q);
          grant_d          = '0;
          state_d          = SCAN;
        end else if (!request[ptr_q]) begin
          grant_d    = '0;
          ptr_d      = w_ptr_next;
          refilled_d = 1'b0;
          state_d    = SCAN;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SCAN;
      ptr_q      <= '0;
      refilled_q <= 1'b0;
      flow_en_q  <= '1;
      grant_q    <= '0;
      size_q     <= '0;
      for (int i = 0; i < N_FLOWS; i++) begin
        deficit_q[i] <= '0;
        quantum_q[i] <= w_quant_rst[i];
      end
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      refilled_q <= refilled_d;
      flow_en_q  <= flow_en_d;
      grant_q    <= grant_d;
      size_q     <= size_d;
      for (int i = 0; i < N_FLOWS; i++) begin
        deficit_q[i] <= deficit_d[i];
        quantum_q[i] <= quantum_d[i];
      end
    end
  end

endmodule
`default_nettype wire
